rc_filter_channel_scheduler: RTL and testbench

- Time-multiplexes one shared RC low-pass multiply datapath across NUM_CHANNELS audio channels.
- On every audio_clk_en it latches all channel inputs, sequences the per-channel update, and publishes all outputs together.
- Per-channel smoothing factor (alpha, 16-bit fraction) is runtime-configurable through a simple write port.
- Sits between sound-generator channel mixers and the final mixer; replaces N parallel filter instances.

---
 rtl/rc_filter_sched_pkg.sv | 11 +
 rtl/rc_filter_channel_scheduler_mac.sv | 30 +++
 rtl/rc_filter_channel_scheduler.sv | 84 ++++++++
 tb/tb_rc_filter_channel_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc_filter_sched_pkg.sv
// rc_filter_sched_pkg: shared types, widths and saturation helper for the RC filter scheduler.
package rc_filter_sched_pkg;
  typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} sched_state_t;
  localparam int SAMPLE_W = 16;
  localparam int ALPHA_W = 16;
  localparam int FRAC_SHIFT = 16;
  localparam int ACC_W = 34;
  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    return (v > 34'sd32767) ? 16'sh7fff : (v < -34'sd32768) ? 16'sh8000 : v[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/rc_filter_channel_scheduler_mac.sv
// rc_filter_mac: shared RC low-pass datapath, registered products then combinational sum and clamp.
module rc_filter_mac
  import rc_filter_sched_pkg::*;
#(
  parameter logic [16:0] LEAK = 17'd65536
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic signed [SAMPLE_W-1:0] x,
  input  logic signed [SAMPLE_W-1:0] st,
  input  logic        [ALPHA_W-1:0]  alpha,
  output logic signed [SAMPLE_W-1:0] y
);
  logic signed [16:0] diff;
  logic signed [ACC_W-1:0] prod, lprod, sum;
  assign diff = {x[15], x} - {st[15], st};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod <= '0;
      lprod <= '0;
    end else if (en) begin
      prod <= $signed({18'd0, alpha}) * $signed({{17{diff[16]}}, diff});
      lprod <= $signed({17'd0, LEAK}) * $signed({{18{st[15]}}, st});
    end
  end
  // arithmetic shifts floor toward -inf
  assign sum = (lprod >>> FRAC_SHIFT) + (prod >>> FRAC_SHIFT);
  assign y = sat16(sum);
endmodule

// File: rtl/rc_filter_channel_scheduler.sv
// rc_filter_channel_scheduler: time-multiplexes one RC low-pass datapath across NUM_CHANNELS channels.
module rc_filter_channel_scheduler
  import rc_filter_sched_pkg::*;
#(
  parameter int          NUM_CHANNELS    = 4,
  parameter logic [15:0] ALPHA_DEFAULT   = 16'd8192,
  parameter logic [16:0] LEAK_16_SHIFTED = 17'd65536
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         audio_clk_en,
  input  logic [16*NUM_CHANNELS-1:0]   in_flat,
  output logic [16*NUM_CHANNELS-1:0]   out_flat,
  output logic                         done,
  output logic                         busy,
  output logic                         overrun,
  input  logic                         overrun_clr,
  input  logic                         cfg_we,
  input  logic [3:0]                   cfg_addr,
  input  logic [15:0]                  cfg_alpha
);
  localparam int CH_W = $clog2(NUM_CHANNELS);
  localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CHANNELS - 1);
  sched_state_t state, state_n;
  logic [CH_W-1:0] ch;
  logic signed [SAMPLE_W-1:0] in_lat [NUM_CHANNELS];
  logic signed [SAMPLE_W-1:0] st [NUM_CHANNELS];
  logic [ALPHA_W-1:0] alpha [NUM_CHANNELS];
  logic signed [SAMPLE_W-1:0] mac_y;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = (state == IDLE) ? (audio_clk_en ? MUL : IDLE) :
              (state == MUL)  ? ACC :
              (state == ACC)  ? ((ch == LAST) ? DONE : MUL) : IDLE;
  end
  always_comb begin
    busy = (state != IDLE);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch <= '0;
      done <= 1'b0;
      overrun <= 1'b0;
      out_flat <= '0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        in_lat[k] <= '0;
        st[k] <= '0;
      end
    end else begin
      done <= (state == DONE);
      // a fresh strobe while busy beats a same-cycle clear
      overrun <= (audio_clk_en && busy) || (overrun && !overrun_clr);
      if (state == IDLE && audio_clk_en) begin
        ch <= '0;
        for (int k = 0; k < NUM_CHANNELS; k++) in_lat[k] <= in_flat[16*k +: 16];
      end
      if (state == ACC) begin
        st[ch] <= mac_y;
        if (ch != LAST) ch <= ch + CH_W'(1);
      end
      if (state == DONE)
        for (int k = 0; k < NUM_CHANNELS; k++) out_flat[16*k +: 16] <= st[k];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_CHANNELS; k++) alpha[k] <= ALPHA_DEFAULT;
    end else if (cfg_we && 32'(cfg_addr) < NUM_CHANNELS) begin
      alpha[cfg_addr[CH_W-1:0]] <= cfg_alpha;
    end
  end
  rc_filter_mac #(.LEAK(LEAK_16_SHIFTED)) u_mac (
    .clk   (clk),
    .reset (reset),
    .en    (state == MUL),
    .x     (in_lat[ch]),
    .st    (st[ch]),
    .alpha (alpha[ch]),
    .y     (mac_y)
  );
endmodule

// File: tb/tb_rc_filter_channel_scheduler.sv
// tb_rc_filter_channel_scheduler: directed self-checking bench for the RC filter scheduler.
module tb_rc_filter_channel_scheduler;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic audio_clk_en = 1'b0;
  logic overrun_clr = 1'b0;
  logic cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [15:0] cfg_alpha = '0;
  logic [16*N-1:0] in_flat = '0;
  logic [16*N-1:0] out_flat;
  logic done, busy, overrun;
  int compared = 0;
  int mismatched = 0;

  rc_filter_channel_scheduler #(.NUM_CHANNELS(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .audio_clk_en (audio_clk_en),
    .in_flat      (in_flat),
    .out_flat     (out_flat),
    .done         (done),
    .busy         (busy),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_alpha    (cfg_alpha)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic signed [15:0] v);
    for (int k = 0; k < N; k++) in_flat[16*k +: 16] = v;
  endtask

  task automatic write_alpha(input logic [3:0] a, input logic [15:0] v);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_alpha = v;
    tick;
    cfg_we = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 20 && done !== 1'b1; i++) tick;
    compared++;
    if (done !== 1'b1) begin
      mismatched++;
      $display("FAIL %s done_timeout: got=%b want=1", name, done);
    end
  endtask

  task automatic run_frame(input string name);
    audio_clk_en = 1'b1;
    tick;
    audio_clk_en = 1'b0;
    wait_done(name);
  endtask

  task automatic test_reset;
    tick;
    compared += 4;
    if (out_flat !== '0) begin mismatched++; $display("FAIL reset_out: got=%h want=0", out_flat); end
    if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got=%b want=0", done); end
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got=%b want=0", busy); end
    if (overrun !== 1'b0) begin mismatched++; $display("FAIL reset_overrun: got=%b want=0", overrun); end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_step;
    for (int k = 0; k < N; k++) write_alpha(4'(k), 16'd32768);
    set_all(16'sd1000);
    run_frame("step1");
    for (int k = 0; k < N; k++) begin
      compared++;
      if (out_flat[16*k +: 16] !== 16'sd500) begin
        mismatched++;
        $display("FAIL step1_ch%0d: got=%0d want=500", k, $signed(out_flat[16*k +: 16]));
      end
    end
    run_frame("step2");
    for (int k = 0; k < N; k++) begin
      compared++;
      if (out_flat[16*k +: 16] !== 16'sd750) begin
        mismatched++;
        $display("FAIL step2_ch%0d: got=%0d want=750", k, $signed(out_flat[16*k +: 16]));
      end
    end
  endtask

  task automatic test_floor;
    do_reset;
    for (int k = 0; k < N; k++) write_alpha(4'(k), 16'd32768);
    set_all(-16'sd1001);
    run_frame("floor");
    for (int k = 0; k < N; k++) begin
      compared++;
      if (out_flat[16*k +: 16] !== -16'sd501) begin
        mismatched++;
        $display("FAIL floor_ch%0d: got=%0d want=-501", k, $signed(out_flat[16*k +: 16]));
      end
    end
  endtask

  task automatic test_latency;
    do_reset;
    set_all(16'sd1000);
    audio_clk_en = 1'b1;
    tick;
    audio_clk_en = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      compared += 3;
      if (busy !== 1'b1) begin mismatched++; $display("FAIL lat_busy_e%0d: got=%b want=1", i - 1, busy); end
      if (done !== 1'b0) begin mismatched++; $display("FAIL lat_done_e%0d: got=%b want=0", i - 1, done); end
      if (out_flat !== '0) begin mismatched++; $display("FAIL lat_out_e%0d: got=%h want=0", i - 1, out_flat); end
      if (i == 4) audio_clk_en = 1'b1;
      tick;
      audio_clk_en = 1'b0;
    end
    compared += 3;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL lat_busy_e9: got=%b want=0", busy); end
    if (done !== 1'b1) begin mismatched++; $display("FAIL lat_done_e9: got=%b want=1", done); end
    if (overrun !== 1'b1) begin mismatched++; $display("FAIL lat_overrun: got=%b want=1", overrun); end
    for (int k = 0; k < N; k++) begin
      compared++;
      if (out_flat[16*k +: 16] !== 16'sd125) begin
        mismatched++;
        $display("FAIL lat_out_ch%0d: got=%0d want=125", k, $signed(out_flat[16*k +: 16]));
      end
    end
    tick;
    compared += 2;
    if (done !== 1'b0) begin mismatched++; $display("FAIL lat_done_pulse: got=%b want=0", done); end
    if (out_flat[15:0] !== 16'sd125) begin mismatched++; $display("FAIL lat_out_hold: got=%0d want=125", $signed(out_flat[15:0])); end
    overrun_clr = 1'b1;
    tick;
    overrun_clr = 1'b0;
    compared++;
    if (overrun !== 1'b0) begin mismatched++; $display("FAIL ovr_clear: got=%b want=0", overrun); end
    audio_clk_en = 1'b1;
    tick;
    overrun_clr = 1'b1;
    tick;
    audio_clk_en = 1'b0;
    overrun_clr = 1'b0;
    compared++;
    if (overrun !== 1'b1) begin mismatched++; $display("FAIL ovr_clr_vs_set: got=%b want=1", overrun); end
    wait_done("ovr_frame");
    overrun_clr = 1'b1;
    tick;
    overrun_clr = 1'b0;
    audio_clk_en = 1'b1;
    tick;
    audio_clk_en = 1'b0;
    for (int i = 1; i <= 8; i++) tick;
    audio_clk_en = 1'b1;
    tick;
    audio_clk_en = 1'b0;
    compared += 3;
    if (done !== 1'b1) begin mismatched++; $display("FAIL done_edge_done: got=%b want=1", done); end
    if (busy !== 1'b0) begin mismatched++; $display("FAIL done_edge_busy: got=%b want=0", busy); end
    if (overrun !== 1'b1) begin mismatched++; $display("FAIL done_edge_overrun: got=%b want=1", overrun); end
    overrun_clr = 1'b1;
    tick;
    overrun_clr = 1'b0;
  endtask

  task automatic test_config;
    logic [15:0] exp;
    do_reset;
    write_alpha(4'd0, 16'd0);
    write_alpha(4'd1, 16'd0);
    write_alpha(4'd2, 16'd65535);
    write_alpha(4'd3, 16'd0);
    write_alpha(4'd7, 16'd65535);
    set_all(16'sd1000);
    run_frame("cfg");
    for (int k = 0; k < N; k++) begin
      exp = (k == 2) ? 16'd999 : 16'd0;
      compared++;
      if (out_flat[16*k +: 16] !== exp) begin
        mismatched++;
        $display("FAIL cfg_ch%0d: got=%0d want=%0d", k, $signed(out_flat[16*k +: 16]), $signed(exp));
      end
    end
    audio_clk_en = 1'b1;
    tick;
    audio_clk_en = 1'b0;
    cfg_we = 1'b1;
    cfg_addr = 4'd0;
    cfg_alpha = 16'd65535;
    tick;
    cfg_we = 1'b0;
    wait_done("cfg_mul_write");
    compared += 2;
    if (out_flat[15:0] !== 16'd0) begin mismatched++; $display("FAIL cfg_old_alpha: got=%0d want=0", $signed(out_flat[15:0])); end
    if (out_flat[47:32] !== 16'd999) begin mismatched++; $display("FAIL cfg_ch2_hold: got=%0d want=999", $signed(out_flat[47:32])); end
    run_frame("cfg_new_alpha");
    compared++;
    if (out_flat[15:0] !== 16'd999) begin mismatched++; $display("FAIL cfg_new_alpha: got=%0d want=999", $signed(out_flat[15:0])); end
  endtask

  task automatic test_reset_mid_frame;
    logic seen;
    do_reset;
    for (int k = 0; k < N; k++) write_alpha(4'(k), 16'd32768);
    set_all(16'sd1000);
    run_frame("pre_abort");
    compared++;
    if (out_flat[15:0] !== 16'sd500) begin mismatched++; $display("FAIL pre_abort_out: got=%0d want=500", $signed(out_flat[15:0])); end
    audio_clk_en = 1'b1;
    tick;
    audio_clk_en = 1'b0;
    tick;
    tick;
    tick;
    reset = 1'b1;
    #1;
    compared += 3;
    if (out_flat !== '0) begin mismatched++; $display("FAIL abort_out: got=%h want=0", out_flat); end
    if (busy !== 1'b0) begin mismatched++; $display("FAIL abort_busy: got=%b want=0", busy); end
    if (done !== 1'b0) begin mismatched++; $display("FAIL abort_done: got=%b want=0", done); end
    tick;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (done === 1'b1) seen = 1'b1;
    end
    compared++;
    if (seen !== 1'b0) begin mismatched++; $display("FAIL abort_no_done: got=%b want=0", seen); end
    run_frame("post_abort");
    for (int k = 0; k < N; k++) begin
      compared++;
      if (out_flat[16*k +: 16] !== 16'sd125) begin
        mismatched++;
        $display("FAIL post_abort_ch%0d: got=%0d want=125", k, $signed(out_flat[16*k +: 16]));
      end
    end
  endtask

  initial begin
    test_reset;
    test_step;
    test_floor;
    test_latency;
    test_config;
    test_reset_mid_frame;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
